// File: rtl/des_iter_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE Feistel rounds per clock, round keys derived on the fly
// from rotating C/D registers, valid/ready on both the block input and the result output.
module des_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] key,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam int ITER = 16 / ROUNDS_PER_CYCLE;

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Eight boxes of four rows; entry index = {box, row, column}.
  localparam int SBOX [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  // Permutation tables count bits from 1 at the MSB.
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] f_blk(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    logic [8:0]  idx;
    x = e_expand(r) ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47:42];
      x   = x << 6;
      idx = {3'(b), six[5], six[0], six[4:1]};
      s   = {s[27:0], 4'(SBOX[idx])};
    end
    return p_perm(s);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[26:0], x[27]};
      2:       return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // rnd is the zero-based round number in processing order.
  function automatic int enc_shift(input int rnd);
    return (rnd == 0 || rnd == 1 || rnd == 8 || rnd == 15) ? 1 : 2;
  endfunction

  // Decryption walks the schedule backwards from C16/D16, which equals the PC-1 state.
  function automatic int dec_shift(input int rnd);
    if (rnd == 0) return 0;
    return (rnd == 1 || rnd == 8 || rnd == 15) ? 1 : 2;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        mode_reg;
  logic [31:0] l_reg, r_reg, l_nxt, r_nxt, tmp;
  logic [27:0] c_reg, d_reg, c_nxt, d_nxt;
  logic [47:0] subkey;
  logic        accept, last;
  int          rnd;

  assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign last      = (state == ROUND) && (cnt == 4'(ITER - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? ROUND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round group: ROUNDS_PER_CYCLE Feistel rounds chained in one clock.
  always_comb begin
    l_nxt  = l_reg;
    r_nxt  = r_reg;
    c_nxt  = c_reg;
    d_nxt  = d_reg;
    subkey = '0;
    tmp    = '0;
    rnd    = 0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd = int'(cnt) * ROUNDS_PER_CYCLE + j;
      if (!mode_reg) begin
        c_nxt = rotl28(c_nxt, enc_shift(rnd));
        d_nxt = rotl28(d_nxt, enc_shift(rnd));
      end else begin
        c_nxt = rotr28(c_nxt, dec_shift(rnd));
        d_nxt = rotr28(d_nxt, dec_shift(rnd));
      end
      subkey = pc2_perm({c_nxt, d_nxt});
      tmp    = r_nxt;
      r_nxt  = l_nxt ^ f_blk(r_nxt, subkey);
      l_nxt  = tmp;
    end
  end

  // State registers: load on accept, advance one round group per clock in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mode_reg <= 1'b0;
      l_reg    <= '0;
      r_reg    <= '0;
      c_reg    <= '0;
      d_reg    <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        {l_reg, r_reg} <= ip_perm(data_in);
        {c_reg, d_reg} <= pc1_perm(key);
        mode_reg       <= mode;
        cnt            <= 4'd0;
      end else if (state == ROUND) begin
        l_reg <= l_nxt;
        r_reg <= r_nxt;
        c_reg <= c_nxt;
        d_reg <= d_nxt;
        cnt   <= cnt + 4'd1;
        if (last) data_out <= fp_perm({r_nxt, l_nxt});
      end
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: three instances (1, 4 and 16 rounds per clock) checked against
// published DES vectors through an expected-result queue.
module tb_des_iter_core;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] C0 = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] CF = 64'h7359B2163E4EDC58;
  localparam logic [63:0] PAR = 64'h0101010101010101;

  typedef struct {
    int          inst;
    logic [63:0] val;
  } sb_t;

  logic        clk, rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        mode      [3];
  logic [63:0] key       [3];
  logic [63:0] data_in   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [63:0] data_out  [3];
  logic        busy      [3];

  int  checks = 0;
  int  failures = 0;
  sb_t sb [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RPC = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    des_iter_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .mode(mode[g]),
      .key(key[g]), .data_in(data_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .data_out(data_out[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on every output handshake.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst && out_valid[g] && out_ready[g]) begin
        if (sb.size() == 0) begin
          check_val("sb_unexpected_out", data_out[g], 64'hX);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check_val("data_out", data_out[g], e.val);
          check_val("out_inst", 64'(g), 64'(e.inst));
        end
      end
    end
  end

  task automatic send(input int g, input logic [63:0] k, input logic [63:0] d, input logic m,
                      input logic [63:0] expv, input bit push, output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    key[g] = k; data_in[g] = d; mode[g] = m; in_valid[g] = 1'b1;
    while (!acc && tries < 64) begin
      @(negedge clk);
      acc = in_ready[g];
      if (acc && push) sb.push_back('{g, expv});
      @(posedge clk); #1;
      tries++;
    end
    if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
    in_valid[g] = 1'b0; key[g] = ~k; data_in[g] = ~d; mode[g] = ~m;
  endtask

  task automatic wait_done(input int g, input int lat, input string tag);
    int n;
    n = 0;
    while (!out_valid[g] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic run_block(input int g, input logic [63:0] k, input logic [63:0] d, input logic m,
                           input logic [63:0] expv, input int lat, input string tag);
    int tries;
    send(g, k, d, m, expv, 1'b1, tries);
    check_val({tag, "_busy"}, 64'(busy[g]), 64'd1);
    wait_done(g, lat, tag);
    @(posedge clk); #1;
  endtask

  initial begin
    int tries;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0; mode[g] = 1'b0; key[g] = '0; data_in[g] = '0; out_ready[g] = 1'b1;
    end
    #2 rst = 1'b1;
    in_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready[0]), 64'd0);
    check_val("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check_val("rst_busy", 64'(busy[0]), 64'd0);
    check_val("rst_data_out", data_out[0], 64'd0);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_block(0, K1, P1, 1'b0, C1, 16, "enc1");
    run_block(0, K1, C1, 1'b1, P1, 16, "dec1");
    run_block(0, K1 ^ PAR, P1, 1'b0, C1, 16, "parity");
    run_block(0, 64'h0, 64'h0, 1'b0, C0, 16, "zero");
    run_block(0, '1, '1, 1'b0, CF, 16, "ones");
    run_block(0, '1, CF, 1'b1, '1, 16, "ones_dec");
    run_block(1, K2, P2, 1'b0, C2, 4, "r4_enc");
    run_block(1, K2, C2, 1'b1, P2, 4, "r4_dec");
    run_block(1, K1, P1, 1'b0, C1, 4, "r4_enc1");
    run_block(2, K2, P2, 1'b0, C2, 1, "r16_enc");
    run_block(2, K1, C1, 1'b1, P1, 1, "r16_dec1");
    run_block(2, 64'h0, C0, 1'b1, 64'h0, 1, "r16_zero_dec");

    // Backpressure, then back-to-back accept on the releasing edge.
    out_ready[0] = 1'b0;
    send(0, K1, P1, 1'b0, C1, 1'b1, tries);
    wait_done(0, 16, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_out_valid", 64'(out_valid[0]), 64'd1);
      check_val("bp_data_out", data_out[0], C1);
      check_val("bp_in_ready", 64'(in_ready[0]), 64'd0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(0, K2, P2, 1'b0, C2, 1'b1, tries);
    check_val("b2b_same_edge", 64'(tries), 64'd1);
    check_val("b2b_out_valid", 64'(out_valid[0]), 64'd0);
    wait_done(0, 16, "b2b");
    @(posedge clk); #1;

    // Reset in the middle of a block.
    run_block(0, K1, P1, 1'b0, C1, 16, "pre_rst");
    send(0, K2, P2, 1'b0, C2, 1'b0, tries);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check_val("midrst_data_out", data_out[0], 64'd0);
    check_val("midrst_busy", 64'(busy[0]), 64'd0);
    check_val("midrst_in_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("post_rst_idle", 64'(out_valid[0]), 64'd0);
    run_block(0, K1, P1, 1'b0, C1, 16, "post_rst");

    repeat (3) @(posedge clk);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
